disp_row_arbiter: RTL and testbench

- Merges the disparity/confidence output streams of two pixel-processing lanes (left eye = source 0, right eye = source 1) into one stream for the downstream packer.
- Interleaves whole decimated rows: row r of source 0, then row r of source 1, then row r+1 of source 0, and so on.
- Tracks column, row and frame position, and tags each output word with source and frame/line markers.
- Single registered output stage with valid/ready backpressure to both sources.

---
 rtl/disp_row_arbiter.sv | 162 ++++++++++++++++
 tb/tb_disp_row_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_row_arbiter.sv
// disp_row_arbiter
// Merges the disparity/confidence streams of the left (source 0) and right
// (source 1) lanes into one stream. Whole decimated rows are interleaved:
// row r of source 0, row r of source 1, then row r+1 of source 0, and so on.
// The output is a single registered stage with valid/ready backpressure.
// Each output word carries its source and row/frame position markers.
module disp_row_arbiter #(
   parameter int disp_bits        = 5,
   parameter int dec_frame_width  = 240,
   parameter int dec_frame_height = 240
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [disp_bits+7:0]   in0_data,
   input  logic                   in0_valid,
   output logic                   in0_ready,
   input  logic [disp_bits+7:0]   in1_data,
   input  logic                   in1_valid,
   output logic                   in1_ready,
   output logic [disp_bits+7:0]   out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_sel,
   output logic                   out_sol,
   output logic                   out_eol,
   output logic                   out_sof,
   output logic                   out_eof,
   output logic                   frame_done,
   output logic                   busy
);

   localparam int ColW = (dec_frame_width  > 1) ? $clog2(dec_frame_width)  : 1;
   localparam int RowW = (dec_frame_height > 1) ? $clog2(dec_frame_height) : 1;
   localparam logic [ColW-1:0] LastCol = ColW'(dec_frame_width - 1);
   localparam logic [RowW-1:0] LastRow = RowW'(dec_frame_height - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROW0 = 2'd1,
      ROW1 = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_nextState;
   logic [ColW-1:0]        r_colCnt;
   logic [RowW-1:0]        r_rowCnt;
   logic [disp_bits+7:0]   r_outData;
   logic                   r_outValid;
   logic                   r_outSel;
   logic                   r_outSol;
   logic                   r_outEol;
   logic                   r_outSof;
   logic                   r_outEof;
   logic                   r_frameDone;
   logic                   w_adv;
   logic                   w_inHs;
   logic                   w_lastCol;
   logic                   w_lastRow;

   // The output register can take a new word when it is empty or being drained
   assign w_adv     = !r_outValid || out_ready;
   assign in0_ready = (r_state == ROW0) && w_adv;
   assign in1_ready = (r_state == ROW1) && w_adv;
   assign w_inHs    = ((r_state == ROW0) && in0_valid && in0_ready) ||
                      ((r_state == ROW1) && in1_valid && in1_ready);
   assign w_lastCol = (r_colCnt == LastCol);
   assign w_lastRow = (r_rowCnt == LastRow);

   assign out_data   = r_outData;
   assign out_valid  = r_outValid;
   assign out_sel    = r_outSel;
   assign out_sol    = r_outSol;
   assign out_eol    = r_outEol;
   assign out_sof    = r_outSof;
   assign out_eof    = r_outEof;
   assign frame_done = r_frameDone;
   assign busy       = (r_state != IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Row sequencing; enable only matters when a frame is about to start
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (enable) begin
               w_nextState = ROW0;
            end
         end
         ROW0: begin
            if (w_inHs && w_lastCol) begin
               w_nextState = ROW1;
            end
         end
         ROW1: begin
            if (w_inHs && w_lastCol) begin
               if (!w_lastRow || enable) begin
                  w_nextState = ROW0;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Column counter advances per accepted word; row counter after each source-1 row
   always_ff @(posedge clk) begin
      if (reset) begin
         r_colCnt <= '0;
         r_rowCnt <= '0;
      end else if (w_inHs) begin
         r_colCnt <= w_lastCol ? '0 : r_colCnt + 1'b1;
         if ((r_state == ROW1) && w_lastCol) begin
            r_rowCnt <= w_lastRow ? '0 : r_rowCnt + 1'b1;
         end
      end
   end

   // Output stage: load on handshake, hold while stalled, empty when drained
   always_ff @(posedge clk) begin
      if (reset) begin
         r_outData   <= '0;
         r_outValid  <= 1'b0;
         r_outSel    <= 1'b0;
         r_outSol    <= 1'b0;
         r_outEol    <= 1'b0;
         r_outSof    <= 1'b0;
         r_outEof    <= 1'b0;
         r_frameDone <= 1'b0;
      end else if (w_inHs) begin
         r_outData   <= (r_state == ROW1) ? in1_data : in0_data;
         r_outValid  <= 1'b1;
         r_outSel    <= (r_state == ROW1);
         r_outSol    <= (r_colCnt == '0);
         r_outEol    <= w_lastCol;
         r_outSof    <= (r_state == ROW0) && (r_rowCnt == '0) && (r_colCnt == '0);
         r_outEof    <= (r_state == ROW1) && w_lastRow && w_lastCol;
         r_frameDone <= (r_state == ROW1) && w_lastRow && w_lastCol;
      end else begin
         r_frameDone <= 1'b0;
         if (out_ready) begin
            r_outValid <= 1'b0;
            r_outSel   <= 1'b0;
            r_outSol   <= 1'b0;
            r_outEol   <= 1'b0;
            r_outSof   <= 1'b0;
            r_outEof   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_disp_row_arbiter.sv
// Testbench for disp_row_arbiter with a 4x2 decimated frame.
// A table of cycle vectors covers one full frame that ends with enable low.
// A frame-order reference model then checks directed and random traffic.
module tb_disp_row_arbiter;

   localparam int DB = 5;
   localparam int DW = DB + 8;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int FW = 2 * W * H;
   localparam int TBL_N = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [DW-1:0] in0_data;
   logic          in0_valid;
   logic          in0_ready;
   logic [DW-1:0] in1_data;
   logic          in1_valid;
   logic          in1_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_sel;
   logic          out_sol;
   logic          out_eol;
   logic          out_sof;
   logic          out_eof;
   logic          frame_done;
   logic          busy;

   int nChecks = 0;
   int nFails  = 0;

   // Frame-level reference model state
   bit            mBusy;
   bit            mValid;
   bit            newWord;
   int            inIdx;
   int            outIdx;
   int            srcCnt[2];
   int            outSrcCnt[2];
   logic [DW-1:0] savData;
   logic [4:0]    savFlags;

   typedef struct {
      bit            en;
      bit            v0;
      bit            v1;
      bit            ordy;
      bit            expValid;
      bit            expBusy;
      bit            expR0;
      bit            expR1;
      bit            expDone;
      logic [4:0]    expFlags;
      logic [DW-1:0] expData;
   } vec_t;

   vec_t tbl[TBL_N];

   disp_row_arbiter #(
      .disp_bits(DB),
      .dec_frame_width(W),
      .dec_frame_height(H)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .in0_data(in0_data),
      .in0_valid(in0_valid),
      .in0_ready(in0_ready),
      .in1_data(in1_data),
      .in1_valid(in1_valid),
      .in1_ready(in1_ready),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sel(out_sel),
      .out_sol(out_sol),
      .out_eol(out_eol),
      .out_sof(out_sof),
      .out_eof(out_eof),
      .frame_done(frame_done),
      .busy(busy)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Word j of source n; distinct per source and index
   function automatic logic [DW-1:0] dataOf(input int n, input int j);
      logic [31:0] t;
      t = 32'((n * 4099 + j * 37 + 11) ^ (j << 5));
      return t[DW-1:0];
   endfunction

   // Expected {sel, sol, eol, sof, eof} of frame word k
   function automatic logic [4:0] flagsOf(input int k);
      int s;
      int col;
      s   = (k / W) % 2;
      col = k % W;
      return {s[0], col == 0, col == W - 1, k == 0, k == FW - 1};
   endfunction

   function automatic logic [4:0] dutFlags();
      return {out_sel, out_sol, out_eol, out_sof, out_eof};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic resetModel();
      mBusy        = 1'b0;
      mValid       = 1'b0;
      newWord      = 1'b1;
      inIdx        = 0;
      outIdx       = 0;
      srcCnt[0]    = 0;
      srcCnt[1]    = 0;
      outSrcCnt[0] = 0;
      outSrcCnt[1] = 0;
   endtask

   task automatic resetDut();
      @(negedge clk);
      reset     = 1'b1;
      enable    = 1'b0;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("rst out_valid", out_valid, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst in0_ready", in0_ready, 0);
      checkOutput("rst in1_ready", in1_ready, 0);
      checkOutput("rst frame_done", frame_done, 0);
      checkOutput("rst out_data", out_data, 0);
      checkOutput("rst flags", dutFlags(), 0);
      reset = 1'b0;
      resetModel();
   endtask

   // One cycle of stimulus; outputs checked against the frame-order model
   task automatic applyStimulus(input bit en, input bit v0, input bit v1, input bit ordy);
      int s;
      int act;
      bit adv;
      bit expR0;
      bit expR1;
      bit expDone;
      bit hs;
      logic [DW-1:0] expData;
      @(negedge clk);
      enable    = en;
      in0_valid = v0;
      in1_valid = v1;
      out_ready = ordy;
      in0_data  = dataOf(0, srcCnt[0]);
      in1_data  = dataOf(1, srcCnt[1]);
      #1;
      act   = (inIdx / W) % 2;
      adv   = !mValid || ordy;
      expR0 = mBusy && (act == 0) && adv;
      expR1 = mBusy && (act == 1) && adv;
      checkOutput("busy", busy, mBusy);
      checkOutput("out_valid", out_valid, mValid);
      checkOutput("in0_ready", in0_ready, expR0);
      checkOutput("in1_ready", in1_ready, expR1);
      expDone = 1'b0;
      if (mValid) begin
         if (newWord) begin
            s       = (outIdx / W) % 2;
            expData = dataOf(s, outSrcCnt[s]);
            checkOutput($sformatf("word%0d data", outIdx), out_data, expData);
            checkOutput($sformatf("word%0d flags", outIdx), dutFlags(), flagsOf(outIdx));
            expDone  = (outIdx == FW - 1);
            savData  = expData;
            savFlags = flagsOf(outIdx);
            outSrcCnt[s]++;
            outIdx = (outIdx + 1) % FW;
         end else begin
            checkOutput("stall data", out_data, savData);
            checkOutput("stall flags", dutFlags(), savFlags);
         end
      end
      checkOutput("frame_done", frame_done, expDone);
      hs      = (act == 0) ? (expR0 && v0) : (expR1 && v1);
      newWord = !(mValid && !ordy);
      mValid  = hs || (mValid && !ordy);
      if (!mBusy) begin
         if (en) mBusy = 1'b1;
      end else if (hs) begin
         srcCnt[act]++;
         inIdx++;
         if (inIdx == FW) begin
            inIdx = 0;
            mBusy = en;
         end
      end
   endtask

   initial begin
      int k;
      int s;
      reset     = 1'b1;
      enable    = 1'b0;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      in0_data  = '0;
      in1_data  = '0;
      out_ready = 1'b1;
      resetModel();
      repeat (2) @(posedge clk);
      resetDut();

      // One frame with all sources valid; enable drops during row 1
      for (int c = 0; c < TBL_N; c++) begin
         tbl[c].en       = (c < 10);
         tbl[c].v0       = 1'b1;
         tbl[c].v1       = 1'b1;
         tbl[c].ordy     = 1'b1;
         tbl[c].expBusy  = (c >= 1) && (c <= FW);
         k               = c - 1;
         tbl[c].expR0    = tbl[c].expBusy && (((k / W) % 2) == 0);
         tbl[c].expR1    = tbl[c].expBusy && (((k / W) % 2) == 1);
         k               = c - 2;
         tbl[c].expValid = (k >= 0) && (k < FW);
         tbl[c].expDone  = (k == FW - 1);
         tbl[c].expFlags = tbl[c].expValid ? flagsOf(k) : 5'd0;
         s               = (k / W) % 2;
         tbl[c].expData  = tbl[c].expValid ? dataOf(s, (k / (2 * W)) * W + k % W) : '0;
      end
      for (int c = 0; c < TBL_N; c++) begin
         @(negedge clk);
         enable    = tbl[c].en;
         in0_valid = tbl[c].v0;
         in1_valid = tbl[c].v1;
         out_ready = tbl[c].ordy;
         in0_data  = dataOf(0, srcCnt[0]);
         in1_data  = dataOf(1, srcCnt[1]);
         #1;
         checkOutput($sformatf("tbl%0d out_valid", c), out_valid, tbl[c].expValid);
         checkOutput($sformatf("tbl%0d busy", c), busy, tbl[c].expBusy);
         checkOutput($sformatf("tbl%0d in0_ready", c), in0_ready, tbl[c].expR0);
         checkOutput($sformatf("tbl%0d in1_ready", c), in1_ready, tbl[c].expR1);
         checkOutput($sformatf("tbl%0d frame_done", c), frame_done, tbl[c].expDone);
         if (tbl[c].expValid) begin
            checkOutput($sformatf("tbl%0d data", c), out_data, tbl[c].expData);
            checkOutput($sformatf("tbl%0d flags", c), dutFlags(), tbl[c].expFlags);
         end
         if (tbl[c].expR0 && tbl[c].v0) srcCnt[0]++;
         if (tbl[c].expR1 && tbl[c].v1) srcCnt[1]++;
      end

      // Source 0 starves during ROW0 while source 1 is valid
      resetDut();
      repeat (3) applyStimulus(1, 1, 1, 1);
      repeat (5) applyStimulus(1, 0, 1, 1);
      for (int i = 0; i < 50 && inIdx != 6; i++) applyStimulus(1, 1, 1, 1);
      checkOutput("six words accepted", inIdx, 6);

      // Reset mid-frame, then restart from source 0 row 0
      resetDut();
      for (int i = 0; i < 48; i++) applyStimulus(1, 1, 1, (i % 4 == 0) || (i % 4 == 3));

      // Random valids, backpressure and enable
      for (int i = 0; i < 800; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      end

      // Back-to-back frames with continuous data
      resetDut();
      for (int i = 0; i < 40; i++) applyStimulus(1, 1, 1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
